irq_ctrl: RTL and testbench

- Interrupt front-end sitting directly upstream of the CP0 block; drives CP0's external interrupt input.
- Synchronises and debounces up to N raw interrupt lines (push-buttons/switches) and latches each clean rising edge as pending.
- Applies a software mask and selects the highest-priority pending source.
- Presents one request edge per interrupt, holding the serviced source in-service until ERET.

---
 rtl/irq_ctrl_if.sv | 29 ++
 rtl/irq_ctrl.sv | 138 +++++++++++++
 tb/tb_irq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Bus between the interrupt front-end and the CPU side (CP0 handshake plus
// software-visible mask/clear/pending registers and the raw interrupt lines).
interface irq_ctrl_if #(
    parameter int N  = 4,
    parameter int CW = 2
);
    logic [N-1:0]  irq_raw;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic          clr_we;
    logic [N-1:0]  clr_wdata;
    logic          ack;
    logic          eret;
    logic          ir_out;
    logic [CW-1:0] ir_cause;
    logic [N-1:0]  pending;
    logic [N-1:0]  mask;
    logic          busy;

    modport master (
        output irq_raw, mask_we, mask_wdata, clr_we, clr_wdata, ack, eret,
        input  ir_out, ir_cause, pending, mask, busy
    );

    modport slave (
        input  irq_raw, mask_we, mask_wdata, clr_we, clr_wdata, ack, eret,
        output ir_out, ir_cause, pending, mask, busy
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt front-end for CP0: synchronise and debounce raw lines, latch rising
// edges as pending, mask, pick the lowest-index winner and hand it to CP0 once.
module irq_ctrl #(
    parameter int           N          = 4,
    parameter int           CW         = 2,
    parameter int           DEB_CYCLES = 4,
    parameter logic [N-1:0] MASK_RST   = {N{1'b1}}
) (
    input  logic      clk,
    input  logic      rst_n,
    irq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    // The counter accepts the change on the edge it would step onto DEB_CYCLES.
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    logic [N-1:0]  s1, s2;
    logic [N-1:0]  stable, stable_d;
    logic [N-1:0]  rise;
    logic [15:0]   deb_cnt [N];

    logic [N-1:0]  pending_q, pending_n;
    logic [N-1:0]  mask_q;
    logic [N-1:0]  active;
    logic [CW-1:0] winner;

    state_t        state_q, state_n;
    logic [CW-1:0] cause_q, cause_n;
    logic          ir_out_q, ir_out_n;
    logic          busy_q, busy_n;
    logic          ack_clr;

    function automatic logic [CW-1:0] lowest_set(input logic [N-1:0] v);
        lowest_set = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = CW'(i);
        end
    endfunction

    // NOTE: state is written with <= so every flop samples the pre-edge values;
    // a blocking = here would let s2 see this cycle's s1 and collapse the chain.
    // NOTE: the per-line debounce counters are ordinary flops, not a RAM, so
    // they are reset along with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < N; i++) deb_cnt[i] <= '0;
        end else begin
            s1       <= bus.irq_raw;
            s2       <= s1;
            stable_d <= stable;
            for (int i = 0; i < N; i++) begin
                if (s2[i] != stable[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        stable[i]  <= s2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 16'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise    = stable & ~stable_d;
    assign active  = pending_q & mask_q;
    assign winner  = lowest_set(active);
    assign ack_clr = (state_q == REQ) && bus.ack;

    // A fresh rise outranks both clear sources so no edge is ever lost.
    // NOTE: pending_n takes its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        pending_n = pending_q;
        for (int i = 0; i < N; i++) begin
            if (rise[i])
                pending_n[i] = 1'b1;
            else if (bus.clr_we && bus.clr_wdata[i])
                pending_n[i] = 1'b0;
            else if (ack_clr && (cause_q == CW'(i)))
                pending_n[i] = 1'b0;
        end
    end

    // ERET returns to IDLE, never straight to REQ, so ir_out always drops for at
    // least one IDLE cycle and CP0 sees a genuine new rising edge.
    always_comb begin
        state_n = state_q;
        cause_n = cause_q;
        unique case (state_q)
            IDLE: if (active != '0) begin
                state_n = REQ;
                cause_n = winner;
            end
            REQ:  if (bus.ack)  state_n = SERV;
            SERV: if (bus.eret) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        ir_out_n = (state_n == REQ);
        busy_n   = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            mask_q    <= MASK_RST;
            state_q   <= IDLE;
            cause_q   <= '0;
            ir_out_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pending_q <= pending_n;
            if (bus.mask_we) mask_q <= bus.mask_wdata;
            state_q   <= state_n;
            cause_q   <= cause_n;
            ir_out_q  <= ir_out_n;
            busy_q    <= busy_n;
        end
    end

    assign bus.ir_out   = ir_out_q;
    assign bus.ir_cause = cause_q;
    assign bus.pending  = pending_q;
    assign bus.mask     = mask_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a sample-history model checked every cycle,
// plus hand-computed expectations pinning latency, priority, masking and reset.
module tb_irq_ctrl;

    localparam int N   = 4;
    localparam int CW  = 2;
    localparam int DEB = 4;

    logic clk;
    logic rst_n;

    irq_ctrl_if #(.N(N), .CW(CW)) bus ();

    irq_ctrl #(
        .N(N), .CW(CW), .DEB_CYCLES(DEB), .MASK_RST(4'b1111)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit started  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the debounced level flips once the last DEB synchronised samples all
    // disagree with it; everything else follows the pending/mask/handshake rules.
    typedef enum {M_IDLE, M_REQ, M_SERV} m_state_t;

    logic [N-1:0]  hist [$];
    logic [N-1:0]  m_stable, m_rise, m_pend, m_mask, m_act, m_nxt;
    logic [CW-1:0] m_cause;
    m_state_t      m_state;
    bit            flip;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            repeat (DEB + 2) hist.push_back('0);
            m_stable = '0;
            m_rise   = '0;
            m_pend   = '0;
            m_mask   = 4'b1111;
            m_cause  = '0;
            m_state  = M_IDLE;
        end else begin
            m_act = m_pend & m_mask;
            m_nxt = m_pend;
            for (int i = 0; i < N; i++) begin
                if (m_rise[i]) m_nxt[i] = 1'b1;
                else if (bus.clr_we && bus.clr_wdata[i]) m_nxt[i] = 1'b0;
                else if (m_state == M_REQ && bus.ack && int'(m_cause) == i) m_nxt[i] = 1'b0;
            end
            case (m_state)
                M_IDLE: if (m_act != '0) begin
                    m_cause = CW'(lowest(m_act));
                    m_state = M_REQ;
                end
                M_REQ:  if (bus.ack)  m_state = M_SERV;
                M_SERV: if (bus.eret) m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
            if (bus.mask_we) m_mask = bus.mask_wdata;
            m_pend = m_nxt;

            // hist[k] is the raw value sampled k edges ago; the debouncer sees hist[2..DEB+1].
            hist.push_front(bus.irq_raw);
            void'(hist.pop_back());
            m_rise = '0;
            for (int i = 0; i < N; i++) begin
                flip = 1'b1;
                for (int k = 2; k <= DEB + 1; k++) if (hist[k][i] == m_stable[i]) flip = 1'b0;
                if (flip) begin
                    m_rise[i]   = ~m_stable[i];
                    m_stable[i] = ~m_stable[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ir_out",   32'(bus.ir_out),   32'(m_state == M_REQ));
            check("ir_cause", 32'(bus.ir_cause), 32'(m_cause));
            check("pending",  32'(bus.pending),  32'(m_pend));
            check("mask",     32'(bus.mask),     32'(m_mask));
            check("busy",     32'(bus.busy),     32'(m_state != M_IDLE));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
    endtask

    task automatic pulse_eret();
        bus.eret = 1'b1;
        step(1);
        bus.eret = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = v;
        step(1);
        bus.mask_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    int low;

    initial begin
        rst_n          = 1'b0;
        bus.irq_raw    = '0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.clr_we     = 1'b0;
        bus.clr_wdata  = '0;
        bus.ack        = 1'b0;
        bus.eret       = 1'b0;
        step(2);
        started = 1;
        rst_n   = 1'b1;
        step(1);
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_ir_out",  32'(bus.ir_out),  32'h0);
        check("rst_mask",    32'(bus.mask),    32'hF);
        check("rst_busy",    32'(bus.busy),    32'h0);

        // Line 2 rises before edge 0 and is held.
        bus.irq_raw = 4'b0100;
        step(6);
        check("lat_pend_e5",  32'(bus.pending),  32'h0);
        step(1);
        check("lat_pend_e6",  32'(bus.pending),  32'h4);
        check("lat_irout_e6", 32'(bus.ir_out),   32'h0);
        step(1);
        check("lat_irout_e7", 32'(bus.ir_out),   32'h1);
        check("lat_cause_e7", 32'(bus.ir_cause), 32'h2);
        step(3);
        pulse_ack();
        check("ack_pending", 32'(bus.pending), 32'h0);
        check("ack_ir_out",  32'(bus.ir_out),  32'h0);
        check("ack_busy",    32'(bus.busy),    32'h1);
        pulse_eret();
        check("eret_busy",   32'(bus.busy),    32'h0);
        bus.irq_raw = '0;
        step(10);

        // Glitch of three cycles on line 1 never gets through.
        bus.irq_raw = 4'b0010;
        step(3);
        bus.irq_raw = '0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check("glitch_pending", 32'(bus.pending), 32'h0);
            check("glitch_ir_out",  32'(bus.ir_out),  32'h0);
        end

        // Lines 3 and 1 together: 1 wins, 3 follows after ERET.
        bus.irq_raw = 4'b1010;
        step(8);
        check("prio_ir_out",  32'(bus.ir_out),   32'h1);
        check("prio_cause",   32'(bus.ir_cause), 32'h1);
        check("prio_pending", 32'(bus.pending),  32'hA);
        low = 0;
        pulse_ack();
        check("prio_ack_pending", 32'(bus.pending), 32'h8);
        if (bus.ir_out == 1'b0) low++;
        pulse_eret();
        if (bus.ir_out == 1'b0) low++;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.ir_out == 1'b1) break;
            low++;
        end
        check("prio_rereq",     32'(bus.ir_out),   32'h1);
        check("prio_cause2",    32'(bus.ir_cause), 32'h3);
        check("prio_low_cycles", 32'(low),         32'd2);
        // ack and eret together in REQ: only the ack counts.
        bus.ack  = 1'b1;
        bus.eret = 1'b1;
        step(1);
        bus.ack  = 1'b0;
        bus.eret = 1'b0;
        check("acketret_busy",   32'(bus.busy),   32'h1);
        check("acketret_ir_out", 32'(bus.ir_out), 32'h0);
        pulse_eret();
        check("acketret_idle",   32'(bus.busy),   32'h0);
        bus.irq_raw = '0;
        step(10);

        // Masked pending source, then unmask.
        write_mask(4'b1110);
        bus.irq_raw = 4'b0001;
        step(10);
        check("mask_pending", 32'(bus.pending), 32'h1);
        check("mask_ir_out",  32'(bus.ir_out),  32'h0);
        write_mask(4'b1111);
        check("unmask_e0_ir_out", 32'(bus.ir_out),   32'h0);
        step(1);
        check("unmask_e1_ir_out", 32'(bus.ir_out),   32'h1);
        check("unmask_cause",     32'(bus.ir_cause), 32'h0);
        pulse_ack();
        pulse_eret();
        bus.irq_raw = '0;
        step(10);

        // Clear colliding with a rise on line 0; stray eret/ack.
        write_mask(4'b1110);
        bus.irq_raw = 4'b0001;
        step(6);
        bus.clr_we    = 1'b1;
        bus.clr_wdata = 4'b0001;
        step(1);
        bus.clr_we    = 1'b0;
        bus.clr_wdata = '0;
        check("collide_pending", 32'(bus.pending), 32'h1);
        pulse_eret();
        check("idle_eret_busy",    32'(bus.busy),    32'h0);
        check("idle_eret_pending", 32'(bus.pending), 32'h1);
        write_mask(4'b1111);
        step(1);
        check("collide_req", 32'(bus.ir_out), 32'h1);
        pulse_ack();
        bus.irq_raw = '0;
        step(8);
        bus.irq_raw = 4'b0001;
        step(8);
        check("serv_repend", 32'(bus.pending), 32'h1);
        pulse_ack();
        check("serv_ack_pending", 32'(bus.pending), 32'h1);
        check("serv_ack_busy",    32'(bus.busy),    32'h1);
        check("serv_ack_ir_out",  32'(bus.ir_out),  32'h0);
        pulse_eret();
        step(1);
        pulse_ack();
        pulse_eret();
        bus.irq_raw = '0;
        step(10);

        // Reset while requesting, with line 2 held across it.
        write_mask(4'b0111);
        bus.irq_raw = 4'b0100;
        step(8);
        check("prerst_ir_out", 32'(bus.ir_out), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("inrst_ir_out",  32'(bus.ir_out),  32'h0);
        check("inrst_pending", 32'(bus.pending), 32'h0);
        check("inrst_busy",    32'(bus.busy),    32'h0);
        check("inrst_mask",    32'(bus.mask),    32'hF);
        step(2);
        rst_n = 1'b1;
        step(6);
        check("postrst_e5_pending", 32'(bus.pending), 32'h0);
        step(1);
        check("postrst_e6_pending", 32'(bus.pending), 32'h4);
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
